// File: rtl/k005297_spdet_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : k005297_spdet_multi_if
// Description : Signal bundle for the K005297 sync-pattern detector.
//               master = stimulus side, slave = detector side.
// Revision    : 1.0 - initial release
// ============================================================================
interface k005297_spdet_multi_if #(
    parameter int CNT_W = 8
);
    logic             i_CLK2M_PCEN_n;
    logic [19:0]      i_ROT20_n;
    logic             i_BDI;
    logic             i_GLCNT_RD;
    logic             i_BOOTEN_n;
    logic             i_BSEN_n;
    logic             i_4BEN_n;
    logic             i_REARM;
    logic             o_SYNCTIP_n;
    logic             o_SYNCED_FLAG;
    logic             o_SYNCED_FLAG_SET_n;
    logic [CNT_W-1:0] o_ZRUN;
    logic             o_TIMEOUT;
    logic [3:0]       o_TIP_CNT;

    modport master (
        output i_CLK2M_PCEN_n, i_ROT20_n, i_BDI, i_GLCNT_RD,
               i_BOOTEN_n, i_BSEN_n, i_4BEN_n, i_REARM,
        input  o_SYNCTIP_n, o_SYNCED_FLAG, o_SYNCED_FLAG_SET_n,
               o_ZRUN, o_TIMEOUT, o_TIP_CNT
    );

    modport slave (
        input  i_CLK2M_PCEN_n, i_ROT20_n, i_BDI, i_GLCNT_RD,
               i_BOOTEN_n, i_BSEN_n, i_4BEN_n, i_REARM,
        output o_SYNCTIP_n, o_SYNCED_FLAG, o_SYNCED_FLAG_SET_n,
               o_ZRUN, o_TIMEOUT, o_TIP_CNT
    );
endinterface
`default_nettype wire

// File: rtl/k005297_spdet_multi.sv
`default_nettype none
// ============================================================================
// Module      : k005297_spdet_multi
// Description : Bubble-memory sync-pattern detector. Counts a run of zero
//               good-loop bits, flags the sync one-bit at the tip phase
//               (direct in 4-bit mode, delayed in 2-bit mode), and tracks
//               synced state, search timeout and tip count.
// Revision    : 1.0 - initial release
// ============================================================================
module k005297_spdet_multi #(
    parameter int ZERO_RUN = 128,
    parameter int CNT_W    = 8,
    parameter int DLY_2B   = 8,
    parameter int PH4      = 18,
    parameter int PH2      = 8,
    parameter int TIMEOUT  = 1024,
    parameter int TO_W     = 11
) (
    input  wire logic                  i_MCLK,
    input  wire logic                  i_SYS_RST_n,
    k005297_spdet_multi_if.slave       bus
);
    localparam logic [CNT_W-1:0] c_ZRUN_MAX = CNT_W'(ZERO_RUN);
    localparam logic [CNT_W-1:0] c_ZRUN_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  c_TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  c_TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  c_TO_SAT   = '1;

    logic              w_tick;
    logic [CNT_W-1:0]  r_zrun_q, w_zrun_d;
    logic [TO_W-1:0]   r_to_q, w_to_d;
    logic              r_tof_q, w_tof_d;
    logic              r_flag_q, w_flag_d;
    logic [3:0]        r_tip_q, w_tip_d;
    logic [DLY_2B-1:0] r_sr_q, w_sr_d;
    logic              w_armed, w_phase, w_raw_n, w_synctip_n, w_set_n;
    logic              w_to_clr, w_to_inc;

    assign w_tick = ~bus.i_CLK2M_PCEN_n;

    // Tip detection: sync one-bit at the selected phase once the zero run is complete
    assign w_armed     = (r_zrun_q == c_ZRUN_MAX);
    assign w_phase     = bus.i_4BEN_n ? ~bus.i_ROT20_n[PH2] : ~bus.i_ROT20_n[PH4];
    assign w_raw_n     = ~(w_phase & bus.i_BDI & w_armed);
    assign w_synctip_n = bus.i_4BEN_n ? r_sr_q[DLY_2B-1] : w_raw_n;
    assign w_set_n     = bus.i_BOOTEN_n | w_synctip_n;

    // Delay line always shifts so a mode switch keeps its history
    generate
        if (DLY_2B == 1) begin : g_sr_single
            assign w_sr_d = w_raw_n;
        end else begin : g_sr_multi
            assign w_sr_d = {r_sr_q[DLY_2B-2:0], w_raw_n};
        end
    endgenerate

    // Next-state for zero-run, synced flag and tip counter
    always_comb begin
        w_zrun_d = r_zrun_q;
        if (bus.i_BSEN_n || r_flag_q) begin
            w_zrun_d = '0;
        end else if (bus.i_GLCNT_RD) begin
            if (bus.i_BDI) begin
                w_zrun_d = '0;
            end else if (r_zrun_q != c_ZRUN_MAX) begin
                w_zrun_d = r_zrun_q + c_ZRUN_ONE;
            end
        end

        w_flag_d = r_flag_q;
        if (!w_set_n) begin
            w_flag_d = 1'b1;
        end else if (bus.i_REARM) begin
            w_flag_d = 1'b0;
        end

        w_tip_d = r_tip_q;
        if (bus.i_REARM) begin
            w_tip_d = 4'd0;
        end else if (!w_synctip_n && r_tip_q != 4'hF) begin
            w_tip_d = r_tip_q + 4'd1;
        end
    end

    // Next-state for the sync search budget and its sticky timeout flag
    always_comb begin
        w_to_clr = bus.i_BSEN_n | r_flag_q | bus.i_REARM;
        w_to_inc = bus.i_GLCNT_RD & ~bus.i_BSEN_n & ~r_flag_q;
        w_to_d   = r_to_q;
        if (w_to_clr) begin
            w_to_d = '0;
        end else if (w_to_inc && r_to_q != c_TO_SAT) begin
            w_to_d = r_to_q + c_TO_ONE;
        end

        w_tof_d = r_tof_q;
        if (bus.i_BSEN_n || bus.i_REARM) begin
            w_tof_d = 1'b0;
        end else if (!w_to_clr && w_to_inc && (r_to_q + c_TO_ONE) == c_TO_LIMIT) begin
            w_tof_d = 1'b1;
        end
    end

    // State registers, advanced only on clock-enabled ticks
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            r_zrun_q <= '0;
            r_to_q   <= '0;
            r_tof_q  <= 1'b0;
            r_flag_q <= 1'b0;
            r_tip_q  <= 4'd0;
            r_sr_q   <= '1;
        end else if (w_tick) begin
            r_zrun_q <= w_zrun_d;
            r_to_q   <= w_to_d;
            r_tof_q  <= w_tof_d;
            r_flag_q <= w_flag_d;
            r_tip_q  <= w_tip_d;
            r_sr_q   <= w_sr_d;
        end
    end

    assign bus.o_SYNCTIP_n         = w_synctip_n;
    assign bus.o_SYNCED_FLAG       = r_flag_q;
    assign bus.o_SYNCED_FLAG_SET_n = w_set_n;
    assign bus.o_ZRUN              = r_zrun_q;
    assign bus.o_TIMEOUT           = r_tof_q;
    assign bus.o_TIP_CNT           = r_tip_q;
endmodule
`default_nettype wire

// File: tb/tb_k005297_spdet_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_k005297_spdet_multi
// Description : Self-checking bench for k005297_spdet_multi against a
//               behavioural reference model (directed + random stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_k005297_spdet_multi;
    localparam int ZERO_RUN = 128;
    localparam int CNT_W    = 8;
    localparam int DLY_2B   = 8;
    localparam int PH4      = 18;
    localparam int PH2      = 8;
    localparam int TIMEOUT  = 1024;
    localparam int TO_W     = 11;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    k005297_spdet_multi_if #(.CNT_W(CNT_W)) bus ();

    k005297_spdet_multi #(
        .ZERO_RUN(ZERO_RUN), .CNT_W(CNT_W), .DLY_2B(DLY_2B),
        .PH4(PH4), .PH2(PH2), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .i_MCLK      (clk),
        .i_SYS_RST_n (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (tip queue holds active-high tips, oldest first)
    int m_zrun, m_to, m_tip;
    bit m_flag, m_tof;
    bit m_dq[$];
    // Current stimulus
    bit c_pcen_n, c_bdi, c_gl, c_booten_n, c_bsen_n, c_fourb_n, c_rearm;
    int c_rot;
    // DUT combinational outputs sampled in the last step
    logic s_synctip_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_zrun = 0; m_to = 0; m_tip = 0; m_flag = 0; m_tof = 0;
        m_dq.delete();
        for (int i = 0; i < DLY_2B; i++) m_dq.push_back(1'b1 ^ 1'b1);
    endtask

    function automatic bit model_raw();
        bit phase;
        phase = (c_rot == (c_fourb_n ? PH2 : PH4));
        return phase && c_bdi && (m_zrun == ZERO_RUN);
    endfunction

    function automatic bit model_tip();
        return c_fourb_n ? m_dq[0] : model_raw();
    endfunction

    task automatic model_tick();
        bit raw, tip, inc, nflag, ntof;
        int nz, nto, ntip;
        raw = model_raw();
        tip = model_tip();
        nflag = (!c_booten_n && tip) ? 1'b1 : (c_rearm ? 1'b0 : m_flag);
        if (c_bsen_n || m_flag) nz = 0;
        else if (c_gl) nz = c_bdi ? 0 : ((m_zrun < ZERO_RUN) ? m_zrun + 1 : ZERO_RUN);
        else nz = m_zrun;
        inc = c_gl && !c_bsen_n && !m_flag;
        if (c_bsen_n || m_flag || c_rearm) nto = 0;
        else if (inc) nto = (m_to < (1 << TO_W) - 1) ? m_to + 1 : m_to;
        else nto = m_to;
        if (c_bsen_n || c_rearm) ntof = 0;
        else if (inc && (m_to + 1 == TIMEOUT)) ntof = 1;
        else ntof = m_tof;
        if (c_rearm) ntip = 0;
        else if (tip) ntip = (m_tip < 15) ? m_tip + 1 : 15;
        else ntip = m_tip;
        m_dq.push_back(raw);
        void'(m_dq.pop_front());
        m_zrun = nz; m_to = nto; m_tof = ntof; m_flag = nflag; m_tip = ntip;
    endtask

    // One clock: drive at negedge, check combinational outputs, tick, check state
    task automatic step(input bit pcen_n, input int rot, input bit bdi, input bit gl,
                        input bit booten_n, input bit bsen_n, input bit fourb_n, input bit rearm);
        bit tip;
        @(negedge clk);
        c_pcen_n = pcen_n; c_rot = rot; c_bdi = bdi; c_gl = gl;
        c_booten_n = booten_n; c_bsen_n = bsen_n; c_fourb_n = fourb_n; c_rearm = rearm;
        bus.i_CLK2M_PCEN_n = pcen_n;
        bus.i_ROT20_n      = ~(20'd1 << rot);
        bus.i_BDI          = bdi;
        bus.i_GLCNT_RD     = gl;
        bus.i_BOOTEN_n     = booten_n;
        bus.i_BSEN_n       = bsen_n;
        bus.i_4BEN_n       = fourb_n;
        bus.i_REARM        = rearm;
        #1;
        tip = model_tip();
        s_synctip_n = bus.o_SYNCTIP_n;
        chk("synctip_n", bus.o_SYNCTIP_n, !tip);
        chk("set_n", bus.o_SYNCED_FLAG_SET_n, booten_n | !tip);
        @(posedge clk);
        if (!pcen_n) model_tick();
        #1;
        chk("flag", bus.o_SYNCED_FLAG, m_flag);
        chk("zrun", bus.o_ZRUN, m_zrun);
        chk("timeout", bus.o_TIMEOUT, m_tof);
        chk("tip_cnt", bus.o_TIP_CNT, m_tip);
    endtask

    task automatic zeros(input int n, input bit booten_n, input bit fourb_n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 19), 0, 1, booten_n, 0, fourb_n, 0);
    endtask

    task automatic nop(input int n, input bit booten_n, input bit fourb_n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 19), 0, 0, booten_n, 0, fourb_n, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_synctip_n"}, bus.o_SYNCTIP_n, 1'b1);
        chk({tag, "_set_n"}, bus.o_SYNCED_FLAG_SET_n, 1'b1);
        chk({tag, "_flag"}, bus.o_SYNCED_FLAG, 1'b0);
        chk({tag, "_zrun"}, bus.o_ZRUN, 0);
        chk({tag, "_timeout"}, bus.o_TIMEOUT, 1'b0);
        chk({tag, "_tip_cnt"}, bus.o_TIP_CNT, 0);
    endtask

    initial begin
        bit seg_booten_n, seg_fourb_n;
        rst_n = 1'b0;
        bus.i_CLK2M_PCEN_n = 1'b0; bus.i_ROT20_n = ~(20'd1 << 18);
        bus.i_BDI = 1'b1; bus.i_GLCNT_RD = 1'b1; bus.i_BOOTEN_n = 1'b0;
        bus.i_BSEN_n = 1'b0; bus.i_4BEN_n = 1'b0; bus.i_REARM = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 4-bit sync: 128 zero good bits then the one bit at phase 18
        zeros(ZERO_RUN, 0, 0);
        chk("armed_zrun", bus.o_ZRUN, ZERO_RUN);
        step(0, PH4, 1, 1, 0, 0, 0, 0);
        chk("sync4_tip", s_synctip_n, 1'b0);
        chk("sync4_flag", bus.o_SYNCED_FLAG, 1'b1);
        chk("sync4_tipcnt", bus.o_TIP_CNT, 1);
        nop(1, 0, 0);
        chk("sync4_zrun", bus.o_ZRUN, 0);

        // Rearm clears the flag and tip count
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rearm_flag", bus.o_SYNCED_FLAG, 1'b0);
        chk("rearm_tipcnt", bus.o_TIP_CNT, 0);

        // One zero short: no tip
        zeros(ZERO_RUN - 1, 0, 0);
        step(0, PH4, 1, 1, 0, 0, 0, 0);
        chk("short_tip", s_synctip_n, 1'b1);
        chk("short_zrun", bus.o_ZRUN, 0);
        chk("short_flag", bus.o_SYNCED_FLAG, 1'b0);

        // Re-sync after rearm
        zeros(ZERO_RUN, 0, 0);
        step(0, PH4, 1, 1, 0, 0, 0, 0);
        chk("resync_flag", bus.o_SYNCED_FLAG, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        nop(DLY_2B + 2, 0, 0);

        // 2-bit sync: tip appears DLY_2B ticks after the raw condition
        zeros(ZERO_RUN, 0, 1);
        step(0, PH2, 1, 1, 0, 0, 1, 0);
        chk("sync2_raw_tip", s_synctip_n, 1'b1);
        for (int k = 1; k <= DLY_2B; k++) begin
            step(0, $urandom_range(0, 19), 0, 0, 0, 0, 1, 0);
            chk("sync2_delay_tip", s_synctip_n, (k == DLY_2B) ? 1'b0 : 1'b1);
        end
        chk("sync2_flag", bus.o_SYNCED_FLAG, 1'b1);

        // Boot disabled: tips repeat, flag stays low, counter stays armed
        step(0, 0, 0, 0, 1, 0, 0, 1);
        zeros(ZERO_RUN, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, PH4, 1, 0, 1, 0, 0, 0);
            nop(2, 1, 0);
        end
        chk("noboot_tipcnt", bus.o_TIP_CNT, 3);
        chk("noboot_flag", bus.o_SYNCED_FLAG, 1'b0);
        chk("noboot_zrun", bus.o_ZRUN, ZERO_RUN);

        // Random traffic with mode flips mid-stream
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                seg_booten_n = 1'($urandom % 2);
                seg_fourb_n  = 1'($urandom % 2);
            end
            step(1'($urandom % 4 == 0),
                 ($urandom % 2 == 0) ? (seg_fourb_n ? PH2 : PH4) : $urandom_range(0, 19),
                 1'($urandom % 64 == 0), 1'($urandom % 4 != 0), seg_booten_n,
                 1'($urandom % 150 == 0), seg_fourb_n, 1'($urandom % 300 == 0));
        end

        // Timeout after TIMEOUT good bits of noise; BSEN_n high clears it
        step(0, 0, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++)
            step(0, $urandom_range(0, 19), 1'($urandom % 2), 1, 1, 0, 0, 0);
        chk("timeout_before", bus.o_TIMEOUT, 1'b0);
        step(0, $urandom_range(0, 19), 1'($urandom % 2), 1, 1, 0, 0, 0);
        chk("timeout_set", bus.o_TIMEOUT, 1'b1);
        nop(3, 1, 0);
        chk("timeout_sticky", bus.o_TIMEOUT, 1'b1);
        step(0, 0, 0, 1, 1, 1, 0, 0);
        chk("timeout_clear", bus.o_TIMEOUT, 1'b0);

        // Asynchronous reset mid-run with zrun at 100
        zeros(100, 1, 0);
        step(0, PH4, 1, 0, 1, 0, 0, 0);
        chk("pre_reset_zrun", bus.o_ZRUN, 100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        zeros(5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
